// File: rtl/mul_acc.sv
// mul_acc: sums a programmed number of 64-bit unsigned products into an
// ACC_W-bit accumulator and hands the result downstream over valid/ready.
// Optional build macro MUL_ACC_SAT_EN: saturate acc to all ones on a carry
// out instead of wrapping modulo 2^ACC_W.
module mul_acc #(
    parameter int unsigned ACC_W = 72
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      len,
    input  logic [63:0]      prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [15:0]      count,
    output logic             busy,
    output logic             ovf
);

    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [15:0]        len_q;
    logic               start_c;
    logic               xfer_c;
    logic               last_c;
    logic [SUM_W-1:0]   sum_c;
    logic [ACC_W-1:0]   acc_next_c;

    // Handshake qualifiers; only the registered state gates them
    always_comb begin
        start_c = (state_q == IDLE) && start;
        xfer_c  = (state_q == ACCUM) && prod_valid;
        last_c  = (count == (len_q - 16'd1));
    end

    // Widened add exposes the carry out of the accumulator
    always_comb begin
        sum_c = {1'b0, acc} + SUM_W'(prod);
`ifdef MUL_ACC_SAT_EN
        acc_next_c = sum_c[ACC_W] ? {ACC_W{1'b1}} : sum_c[ACC_W-1:0];
`else
        acc_next_c = sum_c[ACC_W-1:0];
`endif
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len == 16'd0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (prod_valid && last_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (acc_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register plus status outputs registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            prod_ready <= 1'b0;
            acc_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            prod_ready <= (state_d == ACCUM);
            acc_valid  <= (state_d == DONE);
            busy       <= (state_d != IDLE);
        end
    end

    // Datapath: clear on accepted start, accumulate on each transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q <= 16'd0;
            acc   <= '0;
            count <= 16'd0;
            ovf   <= 1'b0;
        end else if (start_c) begin
            len_q <= len;
            acc   <= '0;
            count <= 16'd0;
            ovf   <= 1'b0;
        end else if (xfer_c) begin
            acc   <= acc_next_c;
            count <= count + 16'd1;
            ovf   <= ovf | sum_c[ACC_W];
        end
    end

endmodule

// File: tb/tb_mul_acc.sv
// Directed self-checking bench for mul_acc: table of short runs plus
// hand-written sequences for backpressure, overflow, long runs and reset.
module tb_mul_acc;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] len;
    logic [63:0] prod;
    logic        prod_valid;
    logic        acc_ready;

    logic        prod_ready;
    logic [71:0] acc;
    logic        acc_valid;
    logic [15:0] count;
    logic        busy;
    logic        ovf;

    logic        prod_ready64;
    logic [63:0] acc64;
    logic        acc_valid64;
    logic [15:0] count64;
    logic        busy64;
    logic        ovf64;

    int n_cmp;
    int n_err;

    mul_acc #(.ACC_W(72)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .prod(prod), .prod_valid(prod_valid), .prod_ready(prod_ready),
        .acc(acc), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .count(count), .busy(busy), .ovf(ovf)
    );

    mul_acc #(.ACC_W(64)) dut64 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .prod(prod), .prod_valid(prod_valid), .prod_ready(prod_ready64),
        .acc(acc64), .acc_valid(acc_valid64), .acc_ready(acc_ready),
        .count(count64), .busy(busy64), .ovf(ovf64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]      len;
        logic [3:0][63:0] p;
        logic [71:0]      exp_acc;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic start_run(input logic [15:0] l);
        @(posedge clk); #1;
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
        len   = 16'hFFFF;
        chk("busy_after_start", 128'(busy), 128'(1));
        chk("prod_ready_after_start", 128'(prod_ready), 128'(l != 16'd0));
        chk("acc_valid_after_start", 128'(acc_valid), 128'(l == 16'd0));
    endtask

    task automatic drain();
        acc_ready = 1'b1;
        @(posedge clk); #1;
        acc_ready = 1'b0;
        chk("acc_valid_after_drain", 128'(acc_valid), 128'(0));
        chk("busy_after_drain", 128'(busy), 128'(0));
    endtask

    task automatic do_run(input vec_t v);
        start_run(v.len);
        for (int i = 0; i < int'(v.len); i++) begin
            prod_valid = 1'b1;
            prod       = v.p[i];
            @(posedge clk); #1;
            chk("count_step", 128'(count), 128'(i + 1));
        end
        prod_valid = 1'b0;
        prod       = 64'd0;
        chk("run_acc_valid", 128'(acc_valid), 128'(1));
        chk("run_prod_ready", 128'(prod_ready), 128'(0));
        chk("run_acc", 128'(acc), 128'(v.exp_acc));
        chk("run_count", 128'(count), 128'(v.len));
        chk("run_ovf", 128'(ovf), 128'(v.exp_ovf));
        drain();
    endtask

    initial begin
        logic [71:0] big;
        logic [63:0] exp64;

        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        start      = 1'b0;
        len        = 16'd0;
        prod       = 64'd0;
        prod_valid = 1'b0;
        acc_ready  = 1'b0;

        vecs[0] = '{16'd3, {64'd0, 64'h30, 64'h20, 64'h10}, 72'h60, 1'b0};
        vecs[1] = '{16'd1, {64'd0, 64'd0, 64'd0, 64'h5}, 72'h5, 1'b0};
        vecs[2] = '{16'd4, {64'd4, 64'd3, 64'd2, 64'd1}, 72'hA, 1'b0};
        vecs[3] = '{16'd2, {64'd0, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF},
                    72'h1_0000_0000_0000_0000, 1'b0};
        vecs[4] = '{16'd0, {64'd0, 64'd0, 64'd0, 64'd0}, 72'h0, 1'b0};

        // Reset state
        #2;
        chk("rst_acc", 128'(acc), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_ovf", 128'(ovf), 128'(0));
        chk("rst_prod_ready", 128'(prod_ready), 128'(0));
        chk("rst_acc_valid", 128'(acc_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // Table-driven runs
        for (int k = 0; k < 5; k++) begin
            do_run(vecs[k]);
        end

        // Bubbles on the product stream and held-off result
        start_run(16'd2);
        prod_valid = 1'b1;
        prod       = 64'h1234;
        @(posedge clk); #1;
        prod_valid = 1'b0;
        prod       = 64'hDEAD;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bubble_count_hold", 128'(count), 128'(1));
            chk("bubble_acc_hold", 128'(acc), 128'(72'h1234));
        end
        prod_valid = 1'b1;
        prod       = 64'h4321;
        @(posedge clk); #1;
        prod_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_acc_valid_held", 128'(acc_valid), 128'(1));
            chk("bp_acc_stable", 128'(acc), 128'(72'h5555));
            @(posedge clk); #1;
        end
        chk("bp_count", 128'(count), 128'(2));
        drain();
        chk("bp_acc_kept_in_idle", 128'(acc), 128'(72'h5555));

        // Carry out of a 64-bit accumulator vs. headroom in the 72-bit one
        start_run(16'd2);
        prod_valid = 1'b1;
        prod       = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        prod       = 64'h2;
        @(posedge clk); #1;
        prod_valid = 1'b0;
`ifdef MUL_ACC_SAT_EN
        exp64 = 64'hFFFF_FFFF_FFFF_FFFF;
`else
        exp64 = 64'h1;
`endif
        chk("ovf64_acc_valid", 128'(acc_valid64), 128'(1));
        chk("ovf64_flag", 128'(ovf64), 128'(1));
        chk("ovf64_acc", 128'(acc64), 128'(exp64));
        chk("ovf72_acc", 128'(acc), 128'(72'h1_0000_0000_0000_0001));
        chk("ovf72_flag", 128'(ovf), 128'(0));
        drain();

        // Long run of maximum products: 256 * (2^32-1)^2 fits in 72 bits
        big = 72'(64'hFFFF_FFFE_0000_0001) * 72'd256;
        start_run(16'd256);
        prod_valid = 1'b1;
        prod       = 64'hFFFF_FFFE_0000_0001;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
        end
        prod_valid = 1'b0;
        chk("max_acc_valid", 128'(acc_valid), 128'(1));
        chk("max_acc", 128'(acc), 128'(big));
        chk("max_count", 128'(count), 128'(256));
        chk("max_ovf", 128'(ovf), 128'(0));
        chk("max_ovf64_sticky", 128'(ovf64), 128'(1));
        drain();

        // Asynchronous reset mid-run, then a fresh run
        start_run(16'd4);
        prod_valid = 1'b1;
        prod       = 64'h7;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_count", 128'(count), 128'(2));
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_acc", 128'(acc), 128'(0));
        chk("mid_rst_count", 128'(count), 128'(0));
        chk("mid_rst_ovf", 128'(ovf), 128'(0));
        chk("mid_rst_prod_ready", 128'(prod_ready), 128'(0));
        chk("mid_rst_acc_valid", 128'(acc_valid), 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        prod_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_run(vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
